// File: rtl/nack_parser.sv
// nack_parser
//   Receives SCMP NACK packets (Ethernet, optional 802.1Q, IPv6, SCMP NACK
//   header) on a 512-bit AXI-Stream port, validates the headers and expands
//   the 64-bit loss bitmap into one retransmission request per missing packet.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   s_axis_*            NACK ingress; byte 0 on tdata[7:0]; tuser[7:0] = inport
//   m_rtx_valid/ready   retransmission request handshake
//   m_rtx_pn            packet number to retransmit (NPN + bit index, mod 2^32)
//   m_rtx_src_ip/dst_ip NACK IPv6 source (data receiver) / destination (sender)
//   m_rtx_vlan          bit15 = VLAN present, [11:0] = VID
//   m_rtx_inport        ingress port the NACK arrived on
//   m_rtx_last          final request of the current NACK
//   stat_*              wrapping counters: accepted, dropped, requests issued
module nack_parser #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_USER_WIDTH = 40,
  parameter int PN_WIDTH        = 32,
  parameter int BITMAP_WIDTH    = 64,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  output logic                       m_rtx_valid,
  input  logic                       m_rtx_ready,
  output logic [PN_WIDTH-1:0]        m_rtx_pn,
  output logic [127:0]               m_rtx_src_ip,
  output logic [127:0]               m_rtx_dst_ip,
  output logic [15:0]                m_rtx_vlan,
  output logic [7:0]                 m_rtx_inport,
  output logic                       m_rtx_last,
  output logic [CNT_WIDTH-1:0]       stat_nack_ok,
  output logic [CNT_WIDTH-1:0]       stat_nack_drop,
  output logic [CNT_WIDTH-1:0]       stat_rtx_req
);

  typedef enum logic [1:0] {ST_RECV, ST_CHECK, ST_EMIT} state_t;

  // Headers end at byte 73 at most: all of beat 0 plus 10 bytes of beat 1.
  localparam int B1_W  = 80;
  localparam int HDR_W = AXIS_DATA_WIDTH + B1_W;
  localparam int IDX_W = $clog2(BITMAP_WIDTH);

  state_t state, state_nxt;

  logic [1:0]                 beat_idx;   // saturates at 2
  logic [AXIS_DATA_WIDTH-1:0] beat0;
  logic [B1_W-1:0]            beat1;
  logic [7:0]                 pkt_len;
  logic [7:0]                 inport_q;
  logic [HDR_W-1:0]           hdr;

  logic [BITMAP_WIDTH-1:0]    work_bmp;   // bit i = wire bit i (MSB-first)
  logic [PN_WIDTH-1:0]        work_npn;
  logic [IDX_W-1:0]           lo_idx;
  logic                       is_last;

  logic                       beat_fire, rtx_fire;
  logic [6:0]                 last_bytes;
  logic [7:0]                 beat_len;

  logic                       f_vlan_en, pkt_ok;
  logic [15:0]                f_vlan;
  logic [127:0]               f_src, f_dst;
  logic [PN_WIDTH-1:0]        f_npn;
  logic [BITMAP_WIDTH-1:0]    f_bmp;

  logic                       unused_ok;
  assign unused_ok = ^s_axis_tuser[AXIS_USER_WIDTH-1:8];

  assign hdr       = {beat1, beat0};
  assign beat_fire = s_axis_tvalid && s_axis_tready;
  assign rtx_fire  = m_rtx_valid && m_rtx_ready;

  function automatic logic [7:0] hb(input logic [HDR_W-1:0] h, input int n);
    return h[8*n +: 8];
  endfunction

  // Byte count of the final beat from the highest set keep bit.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    last_bytes = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
      if (s_axis_tkeep[i]) last_bytes = 7'(i + 1);
    beat_len = {beat_idx, 6'b0} + {1'b0, last_bytes};
  end

  // Header field extraction and validation from the stored beats.
  always_comb begin
    logic [15:0] etype, tci;
    logic [7:0]  bm_byte;
    int          off;
    f_vlan_en = ({hb(hdr, 12), hb(hdr, 13)} == 16'h8100);
    off       = f_vlan_en ? 4 : 0;
    etype     = {hb(hdr, 12 + off), hb(hdr, 13 + off)};
    tci       = {hb(hdr, 14), hb(hdr, 15)};
    f_vlan    = f_vlan_en ? {1'b1, 3'b000, tci[11:0]} : 16'h0000;
    f_src     = '0;
    f_dst     = '0;
    f_npn     = '0;
    f_bmp     = '0;
    bm_byte   = '0;
    for (int k = 0; k < 16; k++) begin
      f_src[8*(15-k) +: 8] = hb(hdr, 22 + off + k);
      f_dst[8*(15-k) +: 8] = hb(hdr, 38 + off + k);
    end
    for (int k = 0; k < 4; k++)
      f_npn[8*(3-k) +: 8] = hb(hdr, 58 + off + k);
    // Wire order is MSB of the first bitmap byte first; store it at index 0.
    for (int k = 0; k < BITMAP_WIDTH / 8; k++) begin
      bm_byte = hb(hdr, 62 + off + k);
      for (int j = 0; j < 8; j++) f_bmp[8*k + j] = bm_byte[7-j];
    end
    pkt_ok = (etype == 16'h86DD) &&
             (hb(hdr, 20 + off) == 8'h92) &&
             (hb(hdr, 54 + off) == 8'h41) &&
             (hb(hdr, 55 + off) == 8'h01) &&
             (pkt_len >= (f_vlan_en ? 8'd74 : 8'd70));
  end

  // Lowest outstanding missing packet and whether it is the only one left.
  always_comb begin
    lo_idx = '0;
    for (int i = BITMAP_WIDTH - 1; i >= 0; i--)
      if (work_bmp[i]) lo_idx = IDX_W'(i);
    is_last = (work_bmp != '0) && ((work_bmp & (work_bmp - 1'b1)) == '0);
  end

  assign s_axis_tready = (state == ST_RECV) && !rst;
  assign m_rtx_valid   = (state == ST_EMIT);
  assign m_rtx_last    = m_rtx_valid && is_last;
  assign m_rtx_pn      = work_npn + PN_WIDTH'(lo_idx);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RECV:  if (beat_fire && s_axis_tlast) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (pkt_ok && f_bmp != '0) ? ST_EMIT : ST_RECV;
      ST_EMIT:  if (rtx_fire && is_last) state_nxt = ST_RECV;
      default:  state_nxt = ST_RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (rst) state <= ST_RECV;
    else     state <= state_nxt;
  end

  // NOTE: the beat buffers carry no reset; a stale or partial buffer is rejected by the length check before use.
  always_ff @(posedge clk) begin
    if (beat_fire && beat_idx == 2'd0) beat0 <= s_axis_tdata;
    if (beat_fire && beat_idx == 2'd1) beat1 <= s_axis_tdata[B1_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx       <= '0;
      pkt_len        <= '0;
      inport_q       <= '0;
      work_bmp       <= '0;
      work_npn       <= '0;
      m_rtx_src_ip   <= '0;
      m_rtx_dst_ip   <= '0;
      m_rtx_vlan     <= '0;
      m_rtx_inport   <= '0;
      stat_nack_ok   <= '0;
      stat_nack_drop <= '0;
      stat_rtx_req   <= '0;
    end else begin
      if (beat_fire) begin
        if (beat_idx == 2'd0) inport_q <= s_axis_tuser[7:0];
        if (s_axis_tlast) begin
          pkt_len  <= beat_len;
          beat_idx <= '0;
        end else if (beat_idx != 2'd2) begin
          beat_idx <= beat_idx + 2'd1;
        end
      end
      if (state == ST_CHECK) begin
        if (pkt_ok) begin
          stat_nack_ok <= stat_nack_ok + 1'b1;
          if (f_bmp != '0) begin
            work_bmp     <= f_bmp;
            work_npn     <= f_npn;
            m_rtx_src_ip <= f_src;
            m_rtx_dst_ip <= f_dst;
            m_rtx_vlan   <= f_vlan;
            m_rtx_inport <= inport_q;
          end
        end else begin
          stat_nack_drop <= stat_nack_drop + 1'b1;
        end
      end
      if (rtx_fire) begin
        work_bmp[lo_idx] <= 1'b0;
        stat_rtx_req     <= stat_rtx_req + 1'b1;
      end
    end
  end

endmodule

// File: doc/nack_parser.md
# nack_parser

Receive-side counterpart of the NACK deparser in the reliability path. Consumes SCMP NACK packets (Ethernet, optional 802.1Q, IPv6, SCMP NACK header) from an AXI-Stream ingress port and validates the headers. It expands the 64-bit loss bitmap into one retransmission request per missing packet number. Sits between the ingress pipeline and the retransmission buffer lookup.

## Interface
- AXIS_DATA_WIDTH, 512, ingress data width; only 512 supported, so a NACK spans at most 2 beats.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, ingress byte enables.
- AXIS_USER_WIDTH, 40, ingress sideband; bits [7:0] = inport.
- PN_WIDTH, 32, packet-number width.
- BITMAP_WIDTH, 64, loss bitmap width.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  AXIS_DATA_WIDTH  NACK bytes; byte 0 on tdata[7:0]; fields big-endian
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  contiguous from bit 0
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- s_axis_tuser  in  AXIS_USER_WIDTH  inport in [7:0]
- m_rtx_valid  out  1  retransmit request valid
- m_rtx_ready  in  1
- m_rtx_pn  out  PN_WIDTH  packet number to retransmit
- m_rtx_src_ip  out  128  NACK IPv6 source, which is the data receiver
- m_rtx_dst_ip  out  128  NACK IPv6 destination, which is the data sender
- m_rtx_vlan  out  16  bit15 = VLAN present, [11:0] = VID, others 0
- m_rtx_inport  out  8
- m_rtx_last  out  1  final request of the current NACK
- stat_nack_ok  out  CNT_WIDTH  valid NACKs accepted
- stat_nack_drop  out  CNT_WIDTH  packets rejected
- stat_rtx_req  out  CNT_WIDTH  requests handed off

## Operation
- Header layout, no VLAN (byte offsets):
  - dst MAC 0–5, src MAC 6–11, ethertype 12–13 = 0x86DD
  - IPv6 header 14–53: next header at 20 = 0x92; src IP 22–37; dst IP 38–53
  - SCMP ptype 54 = 0x41, code 55 = 0x01, checksum 56–57 (ignored)
  - NPN 58–61; bitmap 62–69
  - Minimum length 70 bytes.
- VLAN: ethertype bytes 12–13 = 0x8100 → TCI at 14–15, inner ethertype at 16–17 = 0x86DD, and every later field shifts +4. Minimum length 74 bytes.
- Bitmap bit i (i=0 = MSB of first bitmap byte) set ⇒ packet NPN+i is missing.
- Packet length = 64·(beats before last) + (index of highest set tkeep bit in last beat + 1).
- States:
  - RECV: tready=1. Each accepted beat is stored at beat index 0 or 1. Beats beyond index 1 are accepted and discarded, and the beat index saturates. Latch tuser[7:0] on the first beat. Accepted beat with tlast → CHECK.
  - CHECK: tready=0, one cycle. Valid when all of the following hold: ethertype (or inner ethertype) = 0x86DD, next header 0x92, ptype 0x41, code 0x01, length ≥ minimum.
    - Valid with nonzero bitmap: stat_nack_ok+1, load working bitmap/NPN/IPs/VLAN/inport → EMIT.
    - Valid with zero bitmap: stat_nack_ok+1 → RECV.
    - Invalid: stat_nack_drop+1 → RECV.
  - EMIT: tready=0, m_rtx_valid=1.
    - m_rtx_pn = NPN + i for the lowest set working bit i, computed mod 2^32 (wrap permitted).
    - m_rtx_last=1 when exactly one working bit remains.
    - On m_rtx_valid&&m_rtx_ready: clear bit i, stat_rtx_req+1. If it was last → RECV.
    - All m_rtx_* outputs hold stable while valid&&!ready.
- Counters wrap at 2^CNT_WIDTH.
- Only one NACK in flight; ingress is backpressured during CHECK and EMIT.

## Timing
- Reset: state RECV, s_axis_tready=0 while rst=1 and 1 from the first cycle after; m_rtx_valid=0, m_rtx_last=0, m_rtx_pn/ips/vlan/inport=0, all counters 0.
- rst asserted in any state (including mid-EMIT or mid-packet) aborts the NACK immediately. Pending requests are discarded; counters clear.
- Last beat accepted at edge T → CHECK during cycle T+1 → first m_rtx_valid at T+2.
- One request per cycle under continuous m_rtx_ready. A NACK with k set bits is held in EMIT for k cycles.
- After the last handshake at edge E, tready=1 in cycle E+1. Next packet turnaround is therefore 2 idle cycles beyond the request count.
- s_axis_tready is purely a function of state; it does not depend on m_rtx_ready.

## Test plan
- No VLAN, NPN=0x00000100, bitmap wire bits 0..2 set, m_rtx_ready=1 → pn 0x100, 0x101, 0x102 on consecutive cycles, last only on 0x102; stat_rtx_req=3, stat_nack_ok=1.
- VLAN TCI=0x0005, NPN=0x10, bitmap bits 0 and 63 → pn 0x10 then 0x4F (last); m_rtx_vlan=0x8005; IPs match packet bytes.
- Wrap: NPN=0xFFFFFFFE, bits 0..3 → pn 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Next header 0x11, or a 69-byte no-VLAN packet → no requests, stat_nack_drop increments, tready returns 1 in the cycle after CHECK.
- m_rtx_ready toggling randomly, plus a 3-beat packet (extra beat discarded) and an all-zero bitmap → outputs stable under stall, correct sequence, zero-bitmap NACK yields no request.
- rst pulsed during EMIT with 5 requests outstanding → m_rtx_valid=0 the next cycle, counters 0, a subsequent valid NACK is parsed normally.
